// File: rtl/add_sub_pkg.sv
// Shared constants and types for the add/sub arbiter slice.
package add_sub_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_IDW   = $clog2(DEF_NREQ);

  // Operation select: the sign input picks add (1) or subtract (0).
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Response record at the default configuration: {requester tag, result, overflow}.
  typedef struct packed {
    logic [DEF_IDW-1:0]   id;
    logic [DEF_WIDTH-1:0] result;
    logic                 ovf;
  } rsp_t;

endpackage

// File: rtl/add_sub.sv
// Combinational two's-complement adder/subtractor; result wraps modulo 2^WIDTH.
module add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  assign result = (sign == OP_ADD) ? (a + b) : (a - b);

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among NREQ requesters,
// with a 2-entry in-order response FIFO carrying {id, result, ovf}.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A requester holds valid and operands stable until accepted;
// rsp_* hold stable while rsp_valid && !rsp_ready. req_ready depends
// combinationally on req_valid, rsp_ready and internal state only, never on
// operand data.
module add_sub_arbiter
  import add_sub_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sign,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_ovf,
  output logic                  busy
);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] result;
    logic             ovf;
  } entry_t;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic             found;
  logic [1:0]       count;
  entry_t           head;
  entry_t           tail;
  entry_t           new_entry;
  logic             pop;
  logic             push;
  logic             space;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sign;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  assign pop   = rsp_valid && rsp_ready;
  assign space = (count < 2'd2) || pop;

  // Find the first valid requester at or after the pointer, wrapping to 0.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found  = 1'b1;
        gnt_id = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Only the selected requester sees ready, and only when the FIFO can take a result.
  always_comb begin
    req_ready = '0;
    if (!rst && found && space) req_ready[gnt_id] = 1'b1;
  end

  assign push = !rst && found && space;

  assign sel_a    = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_b    = req_b[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_sign = req_sign[gnt_id];

  add_sub #(.WIDTH(WIDTH)) u_add_sub (
    .a      (sel_a),
    .b      (sel_b),
    .sign   (sel_sign),
    .result (sum)
  );

  // Signed overflow: the result sign disagrees with a's sign when the
  // effective operands (b, or -b for subtract) share a's sign.
  assign ovf = (sel_sign == OP_ADD)
             ? ((sel_a[WIDTH-1] == sel_b[WIDTH-1]) && (sum[WIDTH-1] != sel_a[WIDTH-1]))
             : ((sel_a[WIDTH-1] != sel_b[WIDTH-1]) && (sum[WIDTH-1] != sel_a[WIDTH-1]));

  assign new_entry = '{id: gnt_id, result: sum, ovf: ovf};

  // Advance the round-robin pointer past the requester just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  // Two-slot FIFO: head drives the outputs directly, tail backs it up.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= new_entry;
          else               tail <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= new_entry;
          end else begin
            head <= tail;
            tail <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = (count != 2'd0);
  assign rsp_id     = head.id;
  assign rsp_result = head.result;
  assign rsp_ovf    = head.ovf;
  assign busy       = (count != 2'd0) || (|req_valid);

endmodule
